alu_issue_ctrl: RTL

- Control-side partner of the datapath ALU: accepts one decoded instruction (opcode/funct plus two operands) over a valid/ready handshake.
- Translates opcode/funct into the ALU's 4-bit operation select and drives the ALU operand and select inputs.
- Holds those inputs stable for the operation's required number of cycles, then captures the result and zero flag.
- Returns the captured result over a second valid/ready handshake. Mul/div/mod are treated as multicycle paths.

---
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the datapath ALU: decodes one instruction, holds the ALU
// inputs for the op's latency, captures the result and returns it over valid/ready.
module alu_issue_ctrl #(
    parameter int WIDTH  = 32,
    parameter int MC_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zf,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] sel;
    } dec_t;

    localparam logic [3:0] SEL_IDLE = 4'b1111;
    localparam logic [3:0] MC_CNT   = 4'(MC_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    dec_t       dec;
    logic       dec_mc, dec_divz, go_exec, go_err;

    always_comb begin
        dec = '{legal: 1'b1, sel: SEL_IDLE};
        if (in_opcode == 6'h00) begin
            case (in_funct)
                6'h24:   dec.sel = 4'b0000;
                6'h25:   dec.sel = 4'b0001;
                6'h20:   dec.sel = 4'b0010;
                6'h22:   dec.sel = 4'b0110;
                6'h27:   dec.sel = 4'b0100;
                6'h26:   dec.sel = 4'b0111;
                6'h2A:   dec.sel = 4'b1001;
                6'h18:   dec.sel = 4'b0101;
                6'h1A:   dec.sel = 4'b1000;
                6'h1B:   dec.sel = 4'b0011;
                default: dec.legal = 1'b0;
            endcase
        end else begin
            case (in_opcode)
                6'h08:   dec.sel = 4'b0010;
                6'h0C:   dec.sel = 4'b0000;
                6'h0D:   dec.sel = 4'b0001;
                6'h0E:   dec.sel = 4'b0111;
                6'h0A:   dec.sel = 4'b1001;
                6'h04:   dec.sel = 4'b0110;
                default: dec.legal = 1'b0;
            endcase
        end
    end

    // Divide-by-zero is caught here so the ALU never sees a zero divisor.
    assign dec_mc   = (dec.sel == 4'b0101) || (dec.sel == 4'b1000) || (dec.sel == 4'b0011);
    assign dec_divz = ((dec.sel == 4'b1000) || (dec.sel == 4'b0011)) && (in_b == '0);
    assign go_exec  = (state == IDLE) && in_valid && dec.legal && !dec_divz;
    assign go_err   = (state == IDLE) && in_valid && !(dec.legal && !dec_divz);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go_exec) state_nxt = EXEC;
                  else if (go_err) state_nxt = DONE;
            EXEC: if (cnt == 4'd0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= SEL_IDLE;
            out_res <= '0;
            out_zf  <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (go_exec) begin
                alu_a   <= in_a;
                alu_b   <= in_b;
                alu_sel <= dec.sel;
                cnt     <= dec_mc ? MC_CNT : 4'd0;
            end else if (go_err) begin
                out_res <= '0;
                out_zf  <= 1'b0;
                out_err <= 1'b1;
            end
            if (state == EXEC) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    out_res <= alu_res;
                    out_zf  <= alu_zf;
                    out_err <= 1'b0;
                    alu_sel <= SEL_IDLE;
                end
            end
        end
    end

endmodule
